// File: rtl/cla_pkg.sv
// Shared FSM state type and operation encodings for the pipelined CLA adder.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry-lookahead slice with group generate/propagate.
module cla_slice #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             G,
    output logic             P
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        G    = 1'b0;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            G      = g[i] | (p[i] & G);
        end
        P    = &p;
        sum  = p ^ c[BLOCK-1:0];
        cout = c[BLOCK];
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Multi-cycle adder/subtractor: one BLOCK-bit lookahead slice per cycle.
// Define CLA_OVERFLOW_DETECT_EN to drive the signed overflow flag; otherwise it is tied to 0.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NBLK  = (BLOCK >= 1) ? WIDTH / BLOCK : 1;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, result_q;
    logic               carry_q, cout_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK-1:0]   slice_sum;
    logic               slice_cout, slice_g, slice_p;
    logic               accept, last_slice;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid && in_ready;
    assign last_slice  = (idx_q == IDX_W'(NBLK - 1));
    assign data_result = result_q;
    assign carry_out   = cout_q;

    cla_slice #(.BLOCK(BLOCK)) u_slice (
        .a    (a_q[idx_q*BLOCK +: BLOCK]),
        .b    (b_q[idx_q*BLOCK +: BLOCK]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .G    (slice_g),
        .P    (slice_p)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Inter-slice carry rides the group G/P terms; the final flag takes the slice's own carry out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
        end else if (accept) begin
            a_q     <= data_operandA;
            b_q     <= (op == OP_SUB) ? ~data_operandB : data_operandB;
            carry_q <= (op == OP_SUB);
            idx_q   <= '0;
        end else if (state_q == BUSY) begin
            result_q[idx_q*BLOCK +: BLOCK] <= slice_sum;
            carry_q <= slice_g | (slice_p & carry_q);
            idx_q   <= last_slice ? '0 : idx_q + 1'b1;
            if (last_slice) cout_q <= slice_cout;
        end
    end

`ifdef CLA_OVERFLOW_DETECT_EN
    logic ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY && last_slice) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[BLOCK-1] != a_q[WIDTH-1]);
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, meaning bits added per cycle by one lookahead slice.
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and op valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port op  input  1  0 = add, 1 = subtract (A - B).
REQ-008 SHALL have port data_operandA  input  WIDTH  first operand.
REQ-009 SHALL have port data_operandB  input  WIDTH  second operand.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port data_result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 SHALL have port carry_out  output  1  final carry; for subtract, 1 = no borrow.
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-016 SHALL, on clock edge with in_valid && in_ready, latch A, B_eff = op ? ~B : B, carry register = op, slice index = 0, and enter BUSY.
REQ-017 SHALL, each BUSY cycle, add slice [idx*BLOCK +: BLOCK] of A and B_eff with the carry register via generate/propagate lookahead, write that slice of data_result, update carry register with slice carry, increment idx.
REQ-018 SHALL leave BUSY for DONE on the edge that processes slice NBLK-1, NBLK = WIDTH/BLOCK; out_valid rises exactly NBLK cycles after the accepting edge.
REQ-019 SHALL in DONE hold data_result, carry_out, overflow stable until out_ready = 1, then return to IDLE on that edge; in_ready rises the following cycle (no same-cycle accept).
REQ-020 SHALL ignore in_valid and operand changes outside IDLE.
REQ-021 SHALL compute overflow = (A[WIDTH-1] == B_eff[WIDTH-1]) && (data_result[WIDTH-1] != A[WIDTH-1]).
REQ-022 SHALL fail elaboration when WIDTH % BLOCK != 0 or BLOCK < 1.
REQ-023 SHALL, for WIDTH == BLOCK, complete in one BUSY cycle.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-BUSY, asynchronously force IDLE, idx = 0, carry = 0, data_result = 0, carry_out = 0, overflow = 0, out_valid = 0; in_ready = 1 after release.
REQ-025 SHALL discard any in-flight operation on reset; no partial result is ever presented.

Configuration
REQ-026 SHALL, with macro CLA_OVERFLOW_DETECT_EN defined, drive overflow per REQ-021.
REQ-027 SHALL, without CLA_OVERFLOW_DETECT_EN, keep the overflow port and tie it to 0; all else unchanged.

Structure
REQ-028 SHALL place FSM state enum and op encoding constants (OP_ADD = 0, OP_SUB = 1) in shared package cla_pkg.
REQ-029 SHALL instantiate one combinational sub-module cla_slice (parameter BLOCK; inputs a, b, cin; outputs sum, cout, G, P) for the per-cycle lookahead addition.

Verification (WIDTH = 32, BLOCK = 8)
REQ-030 SHALL cover add 0x000000FF + 0x00000001 -> data_result 0x00000100, carry_out 0, overflow 0, out_valid exactly 4 cycles after accept.
REQ-031 SHALL cover sub 5 - 7 -> 0xFFFFFFFE, carry_out 0, overflow 0; sub 7 - 5 -> 0x00000002, carry_out 1.
REQ-032 SHALL cover add 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow 1 with macro, 0 without.
REQ-033 SHALL cover add 0xFFFFFFFF + 0x00000001 -> 0x00000000, carry_out 1 (carry through all four slices).
REQ-034 SHALL cover reset pulse during second BUSY cycle -> out_valid 0, data_result 0, in_ready 1 after release; next add 3 + 4 -> 7.
REQ-035 SHALL cover out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; release -> IDLE next edge.
